fifo_stream_reader: RTL and testbench

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_reader_pkg.sv | 18 +
 rtl/fifo_reader_buf.sv | 57 +++++
 rtl/fifo_stream_reader.sv | 96 +++++++++
 tb/tb_fifo_stream_reader.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_reader_pkg.sv
// ----------------------------------------------------------------------------
// fifo_reader_pkg
// Shared definitions for the FIFO stream reader: output buffer depth, the
// pointer/count type used for it, and a wrap-around pointer increment.
// Ports: none (package).
// ----------------------------------------------------------------------------
package fifo_reader_pkg;

    localparam int BUF_DEPTH = 3;

    typedef logic [1:0] buf_ptr_t;

    // Advance a buffer pointer, wrapping after the last entry.
    function automatic buf_ptr_t ptr_inc(input buf_ptr_t p);
        return (p == buf_ptr_t'(BUF_DEPTH - 1)) ? buf_ptr_t'(0) : buf_ptr_t'(p + 2'd1);
    endfunction

endpackage

// File: rtl/fifo_reader_buf.sv
// ----------------------------------------------------------------------------
// fifo_reader_buf
// Three-entry in-order register buffer holding words returned by the upstream
// FIFO until the stream sink accepts them.  Push and pop may happen in the
// same cycle; the caller guarantees no push when full and no pop when empty.
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   push, push_data   append push_data at the tail
//   pop               drop the head entry
//   head              current head word (zero while the buffer is empty)
//   count             number of words held (0..3)
// ----------------------------------------------------------------------------
module fifo_reader_buf
    import fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output buf_ptr_t              count
);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    buf_ptr_t              rd_ptr;
    buf_ptr_t              wr_ptr;

    // Storage carries no reset; only pointers and count are cleared.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + buf_ptr_t'(push) - buf_ptr_t'(pop);
        end
    end

    // Forcing zero when empty keeps stale storage off the stream after reset.
    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fifo_stream_reader.sv
// ----------------------------------------------------------------------------
// fifo_stream_reader
// Drains a synchronous FIFO (one-cycle read latency) into a valid/ready stream
// through a three-entry output buffer.  Reads are issued on credit: a read is
// only started when buffered words plus reads still in flight leave room, so
// the buffer can never overflow and fifoRdEn never depends on mReady.
// Optional statistics counters are built when macro FIFO_READER_STATS_EN is
// defined.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   fifoEmpty             upstream FIFO empty flag
//   fifoRdEn              read strobe to the upstream FIFO
//   fifoRdData            read data, valid the cycle after fifoRdEn
//   mValid, mData, mReady output stream
//   occupancy             words currently held in the output buffer
//   statXfer/statStall/statStarve  transfer, stall and starve cycle counters
//                         (FIFO_READER_STATS_EN only)
// ----------------------------------------------------------------------------
module fifo_stream_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fifoEmpty,
    output logic                  fifoRdEn,
    input  logic [DATA_WIDTH-1:0] fifoRdData,
    output logic                  mValid,
    output logic [DATA_WIDTH-1:0] mData,
    input  logic                  mReady,
    output logic [1:0]            occupancy
`ifdef FIFO_READER_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  statXfer,
    output logic [CNT_WIDTH-1:0]  statStall,
    output logic [CNT_WIDTH-1:0]  statStarve
`endif
);

    buf_ptr_t   count;
    logic [1:0] inflight;
    logic       rd_vld_p1;
    logic [2:0] committed;
    logic       pop;

    assign committed = {1'b0, count} + {1'b0, inflight};

    // Reset gating keeps the strobe low while the upstream FIFO is also held.
    assign fifoRdEn = !reset && !fifoEmpty && (committed < 3'(BUF_DEPTH));

    // ---- stage p1: read data returns one cycle after the strobe ----
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_vld_p1 <= 1'b0;
            inflight  <= '0;
        end else begin
            rd_vld_p1 <= fifoRdEn;
            inflight  <= inflight + 2'(fifoRdEn) - 2'(rd_vld_p1);
        end
    end

    assign mValid    = (count != '0);
    assign pop       = mValid && mReady;
    assign occupancy = count;

    // A word returning during reset is dropped: the buffer ignores it because
    // its pointers and count are held at zero by the same reset.
    fifo_reader_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clock     (clock),
        .reset     (reset),
        .push      (rd_vld_p1),
        .push_data (fifoRdData),
        .pop       (pop),
        .head      (mData),
        .count     (count)
    );

`ifdef FIFO_READER_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            statXfer   <= '0;
            statStall  <= '0;
            statStarve <= '0;
        end else begin
            statXfer   <= statXfer   + CNT_WIDTH'(mValid && mReady);
            statStall  <= statStall  + CNT_WIDTH'(mValid && !mReady);
            statStarve <= statStarve + CNT_WIDTH'(!mValid && mReady);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          fifoEmpty = 1'b1;
    logic          fifoRdEn;
    logic [DW-1:0] fifoRdData = '0;
    logic          mValid;
    logic [DW-1:0] mData;
    logic          mReady = 1'b0;
    logic [1:0]    occupancy;
`ifdef FIFO_READER_STATS_EN
    logic [CW-1:0] statXfer;
    logic [CW-1:0] statStall;
    logic [CW-1:0] statStarve;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_q[$];
    logic          prev_rd = 1'b0;

    always #5 clock = ~clock;

    fifo_stream_reader #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .fifoEmpty  (fifoEmpty),
        .fifoRdEn   (fifoRdEn),
        .fifoRdData (fifoRdData),
        .mValid     (mValid),
        .mData      (mData),
        .mReady     (mReady),
        .occupancy  (occupancy)
`ifdef FIFO_READER_STATS_EN
        ,
        .statXfer   (statXfer),
        .statStall  (statStall),
        .statStarve (statStarve)
`endif
    );

    // Upstream FIFO model: a read strobe seen at an edge delivers the next word
    // shortly after that edge, so it is stable for the following edge.
    initial forever begin
        logic rd;
        @(posedge clock);
        rd = fifoRdEn;
        #1;
        if (rd === 1'b1) begin
            vectors++;
            if (src_q.size() == 0) begin
                miscompares++;
                $display("FAIL underflow: fifoRdEn=1 with empty fifo, required no read");
            end else begin
                fifoRdData = src_q.pop_front();
            end
        end
        fifoEmpty = (src_q.size() == 0);
    end

    // Output scoreboard and invariant monitor.
    initial forever begin
        logic [DW-1:0] exp;
        @(negedge clock);
        vectors++;
        if ((int'(occupancy) + int'(prev_rd)) > 3 || (fifoRdEn === 1'b1 && fifoEmpty)) begin
            miscompares++;
            $display("FAIL invariant: occupancy=%0d inflight=%0d rden=%b empty=%b, required occ+inflight<=3 and no read when empty",
                     occupancy, prev_rd, fifoRdEn, fifoEmpty);
        end
        prev_rd = (fifoRdEn === 1'b1);
        if (mValid === 1'b1 && mReady) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL stream_extra: got mData=%02h, required no output", mData);
            end else begin
                exp = exp_q.pop_front();
                if (mData !== exp) begin
                    miscompares++;
                    $display("FAIL stream_order: got mData=%02h, required %02h", mData, exp);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        src_q.push_back(w);
        exp_q.push_back(w);
        fifoEmpty = 1'b0;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        mReady = 1'b0;
        step();
        src_q.delete();
        exp_q.delete();
        fifoEmpty = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d words still expected, required 0", exp_q.size());
        end
        repeat (3) step();
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        mReady = 1'b0;
        push_word(8'h5A);
        push_word(8'hA5);
        repeat (3) begin
            @(negedge clock);
            vectors++;
            if (fifoRdEn !== 1'b0) begin
                miscompares++;
                $display("FAIL rden_in_reset: got %b, required 0", fifoRdEn);
            end
            step();
        end
        src_q.delete();
        exp_q.delete();
        fifoEmpty = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        vectors++;
        if (fifoRdEn !== 1'b0 || mValid !== 1'b0 || occupancy !== 2'd0 || mData !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_state: rden=%b mValid=%b occ=%0d mData=%02h, required 0/0/0/00",
                     fifoRdEn, mValid, occupancy, mData);
        end
`ifdef FIFO_READER_STATS_EN
        vectors++;
        if (statXfer !== '0 || statStall !== '0) begin
            miscompares++;
            $display("FAIL reset_stats: xfer=%0d stall=%0d, required 0/0", statXfer, statStall);
        end
`endif
        step();
    endtask

    task automatic test_basic();
        logic          ev[6];
        logic          er[6];
        logic [DW-1:0] ed[6];
        ev = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        er = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        ed = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
        do_reset();
        mReady = 1'b1;
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            vectors++;
            if (mValid !== ev[c] || fifoRdEn !== er[c] || (ev[c] && mData !== ed[c])) begin
                miscompares++;
                $display("FAIL basic_cycle%0d: mValid=%b rden=%b mData=%02h, required %b/%b/%02h",
                         c, mValid, fifoRdEn, mData, ev[c], er[c], ed[c]);
            end
        end
`ifdef FIFO_READER_STATS_EN
        vectors++;
        if (statXfer !== 4'd3) begin
            miscompares++;
            $display("FAIL basic_statxfer: got %0d, required 3", statXfer);
        end
`endif
        step();
    endtask

    task automatic test_stall();
        int            pulses;
        logic          prev_v;
        logic [CW-1:0] prev_stall;
        logic [CW-1:0] want_stall;
        pulses = 0;
        prev_v = 1'b0;
        prev_stall = '0;
        do_reset();
        mReady = 1'b0;
        for (int i = 0; i < 8; i++) push_word(8'(8'h40 + i));
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (fifoRdEn === 1'b1) pulses++;
            if (mValid === 1'b1) begin
                vectors++;
                if (mData !== 8'h40) begin
                    miscompares++;
                    $display("FAIL stall_hold: mData=%02h, required 40", mData);
                end
            end
`ifdef FIFO_READER_STATS_EN
            want_stall = prev_stall + 4'd1;
            if (prev_v) begin
                vectors++;
                if (statStall !== want_stall) begin
                    miscompares++;
                    $display("FAIL stall_stat: got %0d, required %0d", statStall, want_stall);
                end
            end
            prev_stall = statStall;
`endif
            prev_v = (mValid === 1'b1);
        end
        vectors++;
        if (pulses != 3 || occupancy !== 2'd3 || mValid !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_fill: pulses=%0d occ=%0d mValid=%b, required 3/3/1", pulses, occupancy, mValid);
        end
        step();
        mReady = 1'b1;
        wait_drain(100);
    endtask

    task automatic test_back_to_back();
        logic er;
        logic ev;
        do_reset();
        mReady = 1'b1;
        for (int i = 0; i < 16; i++) push_word(8'(8'h80 + i));
        for (int c = 0; c < 20; c++) begin
            er = (c < 16);
            ev = (c >= 2 && c < 18);
            @(negedge clock);
            vectors++;
            if (fifoRdEn !== er || mValid !== ev) begin
                miscompares++;
                $display("FAIL b2b_cycle%0d: rden=%b mValid=%b, required %b/%b", c, fifoRdEn, mValid, er, ev);
            end
        end
        step();
        wait_drain(20);
    endtask

    task automatic test_random();
        int pushed;
        int n;
        pushed = 0;
        n = 0;
        do_reset();
        while ((pushed < 1000 || exp_q.size() != 0) && n < 20000) begin
            mReady = 1'($urandom_range(0, 1));
            if (pushed < 1000 && $urandom_range(0, 3) != 0) begin
                push_word(8'($urandom));
                pushed++;
            end
            step();
            n++;
        end
        vectors++;
        if (pushed != 1000 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL random_complete: pushed=%0d outstanding=%0d, required 1000/0", pushed, exp_q.size());
        end
        mReady = 1'b0;
        step();
    endtask

    task automatic test_reset_inflight();
        do_reset();
        mReady = 1'b1;
        push_word(8'hC3);
        @(negedge clock);
        vectors++;
        if (fifoRdEn !== 1'b1) begin
            miscompares++;
            $display("FAIL inflight_rden: got %b, required 1", fifoRdEn);
        end
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        src_q.delete();
        exp_q.delete();
        fifoEmpty = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            vectors++;
            if (mValid !== 1'b0 || occupancy !== 2'd0) begin
                miscompares++;
                $display("FAIL inflight_discard%0d: mValid=%b occ=%0d, required 0/0", c, mValid, occupancy);
            end
        end
        step();
    endtask

    task automatic test_stats_wrap();
        do_reset();
        mReady = 1'b1;
        for (int i = 0; i < 17; i++) push_word(8'(8'hE0 + i));
        wait_drain(60);
`ifdef FIFO_READER_STATS_EN
        vectors++;
        if (statXfer !== 4'd1) begin
            miscompares++;
            $display("FAIL stats_wrap: statXfer=%0d, required 1", statXfer);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_random();
        test_reset_inflight();
        test_stats_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
